// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with
// pending-write scoreboard.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: array mux, write bypass compare
// and scoreboard busy lookup.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = regfile_pkg::CNT_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  input  logic [CNT_W-1:0]  cnt [2**ADDR_W],
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic nz;
  logic hit;
  logic [CNT_W-1:0] c;

  always_comb begin
    nz  = rd_addr != ADDR_W'(REG_ZERO);
    hit = (BYPASS != 0) && wr_en
        && (wr_addr == rd_addr) && nz;
    c   = cnt[rd_addr];
    rd_data = '0;
    if (nz) begin
      rd_data = hit ? wr_data : mem[rd_addr];
    end
    // last producer retiring this cycle is already visible
    rd_busy = nz && (c != '0)
            && !(hit && (c == CNT_W'(1)));
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with optional write
// bypass and per-register pending-write counters.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int N_RD   = 2,
  parameter int BYPASS = 1,
  parameter int CNT_W  = regfile_pkg::CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   iss_ready,
  output logic                   err_underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q [DEPTH];
  logic [CNT_W-1:0]  cnt_d [DEPTH];
  logic              err_q;
  logic              err_d;

  // a retiring write frees a slot in the same cycle
  always_comb begin
    iss_ready = !((iss_addr != ZERO)
              && (cnt_q[iss_addr] == CNT_MAX)
              && !(wr_en && (wr_addr == iss_addr)));
  end

  always_comb begin
    logic inc;
    logic dec;
    mem_d = mem_q;
    cnt_d = cnt_q;
    err_d = err_q;
    inc   = 1'b0;
    dec   = 1'b0;
    if (wr_en && (wr_addr != ZERO)) begin
      mem_d[wr_addr] = wr_data;
    end
    for (int r = 1; r < DEPTH; r++) begin
      inc = iss_en && iss_ready
          && (iss_addr == ADDR_W'(r));
      dec = wr_en && (wr_addr == ADDR_W'(r));
      if (inc && !dec) begin
        cnt_d[ADDR_W'(r)] = cnt_q[ADDR_W'(r)] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q[ADDR_W'(r)] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[ADDR_W'(r)] = cnt_q[ADDR_W'(r)] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .mem     (mem_q),
      .cnt     (cnt_q),
      .rd_data (rd_data[p*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard,
// with a BYPASS=0 twin for the no-forwarding case.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        err_underflow;

  logic [63:0] rd_data0;
  logic [1:0]  rd_busy0;
  logic        iss_ready0;
  logic        err_underflow0;

  int n_cmp;
  int n_bad;

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .N_RD(2),
    .BYPASS(1), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .err_underflow(err_underflow)
  );

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .N_RD(2),
    .BYPASS(0), .CNT_W(2)
  ) dut0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ready(iss_ready0), .err_underflow(err_underflow0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit [4:0]  a0;
    bit [4:0]  a1;
    bit        ie;
    bit [4:0]  ia;
    bit [31:0] d0;
    bit [31:0] d1;
    bit        b0;
    bit        b1;
    bit        rdy;
    bit        err;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input int r, input int we, input int wa, input int wd,
    input int a0, input int a1, input int ie, input int ia,
    input int d0, input int d1, input int b0, input int b1,
    input int rdy, input int err);
    vec_t v;
    v.rst = 1'(r);   v.we = 1'(we);
    v.wa  = 5'(wa);  v.wd = 32'(wd);
    v.a0  = 5'(a0);  v.a1 = 5'(a1);
    v.ie  = 1'(ie);  v.ia = 5'(ia);
    v.d0  = 32'(d0); v.d1 = 32'(d1);
    v.b0  = 1'(b0);  v.b1 = 1'(b1);
    v.rdy = 1'(rdy); v.err = 1'(err);
    vq.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst      = v.rst;
    wr_en    = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    rd_addr  = {v.a1, v.a0};
    iss_en   = v.ie;
    iss_addr = v.ia;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; iss_en = 1'b0; iss_addr = '0;

    //  rst we wa  wd           a0 a1 ie ia  d0           d1      b0 b1 rdy err
    add(0, 0, 0,  0,           0, 1, 0, 0,  0,          0,       0, 0, 1, 0);
    add(0, 0, 0,  0,          31,31, 0, 0,  0,          0,       0, 0, 1, 0);
    add(0, 0, 0,  0,           5, 0, 1, 5,  0,          0,       0, 0, 1, 0);
    add(0, 0, 0,  0,           5, 5, 0, 0,  0,          0,       1, 1, 1, 0);
    add(0, 1, 5,  'hDEADBEEF,  5, 1, 0, 0,  'hDEADBEEF, 0,       0, 0, 1, 0);
    add(0, 0, 0,  0,           5, 5, 0, 0,  'hDEADBEEF, 'hDEADBEEF, 0, 0, 1, 0);
    add(0, 1, 0,  'h12345678,  0, 0, 0, 0,  0,          0,       0, 0, 1, 0);
    add(0, 0, 0,  0,           0, 0, 1, 0,  0,          0,       0, 0, 1, 0);
    add(0, 0, 0,  0,           0, 0, 0, 0,  0,          0,       0, 0, 1, 0);
    add(0, 0, 0,  0,           7, 7, 1, 7,  0,          0,       0, 0, 1, 0);
    add(0, 0, 0,  0,           7, 7, 1, 7,  0,          0,       1, 1, 1, 0);
    add(0, 0, 0,  0,           7, 7, 1, 7,  0,          0,       1, 1, 1, 0);
    add(0, 0, 0,  0,           7, 7, 1, 7,  0,          0,       1, 1, 0, 0);
    add(0, 1, 7,  'hA1,        7, 7, 0, 0,  'hA1,       'hA1,    1, 1, 1, 0);
    add(0, 1, 7,  'hA2,        7, 7, 0, 0,  'hA2,       'hA2,    1, 1, 1, 0);
    add(0, 1, 7,  'hA3,        7, 7, 0, 0,  'hA3,       'hA3,    0, 0, 1, 0);
    add(0, 0, 0,  0,           7, 7, 0, 0,  'hA3,       'hA3,    0, 0, 1, 0);
    add(0, 0, 0,  0,           9, 9, 1, 9,  0,          0,       0, 0, 1, 0);
    add(0, 1, 9,  'h99,        9, 9, 1, 9,  'h99,       'h99,    0, 0, 1, 0);
    add(0, 0, 0,  0,           9, 9, 0, 0,  'h99,       'h99,    1, 1, 1, 0);
    add(0, 1, 12, 'hCC,       12,12, 0, 0,  'hCC,       'hCC,    0, 0, 1, 0);
    add(0, 0, 0,  0,          12,12, 0, 0,  'hCC,       'hCC,    0, 0, 1, 1);
    add(0, 0, 0,  0,          12, 9, 1, 12, 'hCC,       'h99,    0, 1, 1, 1);
    add(0, 0, 0,  0,          12,12, 0, 0,  'hCC,       'hCC,    1, 1, 1, 1);
    add(0, 0, 0,  0,           3, 3, 1, 3,  0,          0,       0, 0, 1, 1);
    add(0, 0, 0,  0,           3, 3, 1, 3,  0,          0,       1, 1, 1, 1);
    add(0, 0, 0,  0,           3, 3, 1, 3,  0,          0,       1, 1, 1, 1);
    add(0, 1, 3,  'h33,        3, 3, 1, 3,  'h33,       'h33,    1, 1, 1, 1);
    add(0, 0, 0,  0,           3, 9, 1, 3,  'h33,       'h99,    1, 1, 0, 1);
    add(1, 1, 7,  'hFF,        3, 9, 1, 3,  'h33,       'h99,    1, 1, 0, 1);
    add(0, 0, 0,  0,           3, 9, 0, 3,  0,          0,       0, 0, 1, 0);
    add(0, 0, 0,  0,           7,12, 0, 0,  0,          0,       0, 0, 1, 0);

    @(posedge clk);
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      drive(vq[i]);
      @(negedge clk);
      chk($sformatf("v%0d d0", i), rd_data[31:0], vq[i].d0);
      chk($sformatf("v%0d d1", i), rd_data[63:32], vq[i].d1);
      chk($sformatf("v%0d b0", i), 32'(rd_busy[0]), 32'(vq[i].b0));
      chk($sformatf("v%0d b1", i), 32'(rd_busy[1]), 32'(vq[i].b1));
      chk($sformatf("v%0d rdy", i), 32'(iss_ready), 32'(vq[i].rdy));
      chk($sformatf("v%0d err", i), 32'(err_underflow), 32'(vq[i].err));
      @(posedge clk);
      #1;
    end

    // no-forwarding twin: same-cycle write is not visible
    rst = 1'b0; wr_en = 1'b0; iss_en = 1'b1;
    iss_addr = 5'd5; rd_addr = {5'd5, 5'd5};
    @(posedge clk); #1;
    iss_en = 1'b0; wr_en = 1'b1;
    wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("nobyp d0", rd_data0[31:0], 32'h0);
    chk("nobyp b0", 32'(rd_busy0[0]), 32'h1);
    chk("byp d0", rd_data[31:0], 32'hDEADBEEF);
    chk("byp b0", 32'(rd_busy[0]), 32'h0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("nobyp d0 next", rd_data0[31:0], 32'hDEADBEEF);
    chk("nobyp b0 next", 32'(rd_busy0[0]), 32'h0);
    chk("byp d1 next", rd_data[63:32], 32'hDEADBEEF);
    chk("nobyp err", 32'(err_underflow0), 32'h0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
